// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier result path: default widths,
// FIFO depth and the capture state encoding used by product_collector.
package mult_pkg;

    localparam int MULT_W     = 5;
    localparam int MULT_DEPTH = 4;
    localparam int MULT_PW    = 2 * MULT_W;

    typedef enum logic {
        IDLE = 1'b0,
        LO   = 1'b1
    } cap_state_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is presented combinationally,
// with a separate occupancy counter so full and empty are unambiguous.
module sync_fifo
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_PW,
    parameter int DEPTH = MULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_drop,
    input  logic                       pop_req,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;

    logic empty_w;
    logic full_w;
    logic pop_w;
    logic push_ok_w;

    assign empty_w   = (count_reg == '0);
    assign full_w    = (count_reg == CW'(DEPTH));
    assign pop_w     = pop_req && !empty_w;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign push_ok_w = push && (!full_w || pop_w);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok_w) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop_w) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        unique case ({push_ok_w, pop_w})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_reg.
    always_ff @(posedge clk) begin
        if (push_ok_w) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign out_data  = mem[rd_ptr_reg];
    assign out_valid = !empty_w;
    assign count     = count_reg;
    assign full      = full_w;
    assign push_drop = push && !push_ok_w;

endmodule

// File: rtl/product_collector.sv
// Collects the two-beat {hi, lo} product stream behind the Booth multiplier
// and queues assembled products for a valid/ready consumer.
module product_collector
    import mult_pkg::*;
#(
    parameter int W     = MULT_W,
    parameter int DEPTH = MULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mul_done,
    input  logic [W-1:0]               mul_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*W-1:0]             out_product,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    cap_state_t     state_reg, state_next;
    logic [W-1:0]   hi_reg;
    logic           overflow_reg;
    logic           push_w;
    logic           drop_w;
    logic [2*W-1:0] push_data_w;

    // In LO every beat is the low half, even if mul_done is (wrongly) raised again.
    always_comb begin
        state_next = state_reg;
        push_w     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (mul_done) begin
                    state_next = LO;
                end
            end
            LO: begin
                push_w     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign push_data_w = {hi_reg, mul_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            hi_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && mul_done) begin
                hi_reg <= mul_data;
            end
        end
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
        end else if (drop_w) begin
            overflow_reg <= 1'b1;
        end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_w),
        .push_data (push_data_w),
        .push_drop (drop_w),
        .pop_req   (out_ready),
        .out_valid (out_valid),
        .out_data  (out_product),
        .count     (count),
        .full      (full)
    );

    assign overflow = overflow_reg;

endmodule

// File: doc/product_collector.md
# product_collector

Downstream stage of the 5-bit Booth multiplier. It captures the two-beat product stream that the multiplier emits after `done`, assembles each 10-bit product, and buffers up to DEPTH products in a first-word-fall-through FIFO. Results leave through a valid/ready port. A `full` flag lets the top-level sequencer hold off further `start` pulses.

## Interface
Parameters:
- W, 5: multiplier data_out width; one product is 2W bits
- DEPTH, 4: FIFO entries, power of two ≥ 2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- mul_done  in  1  multiplier `done`; one-cycle pulse
- mul_data  in  W  multiplier `data_out`
- out_valid  out  1  FIFO head holds a product
- out_ready  in  1  consumer accepts the head this cycle
- out_product  out  2W  head product {hi, lo}, raw two's-complement
- count  out  $clog2(DEPTH)+1  entries currently stored
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a product was dropped
- clr_ovf  in  1  synchronous clear of `overflow`

## Operation
Multiplier output protocol, fixed for this design:
- The beat on which `mul_done`=1 carries the high half (product[2W-1:W]) on `mul_data`.
- The beat on the next cycle carries the low half (product[W-1:0]).

Capture FSM, two states:
- IDLE: on `mul_done`=1, latch hi_reg ← mul_data and go to LO. Otherwise stay.
- LO: unconditionally take `mul_data` as lo, form {hi_reg, mul_data}, issue a push, return to IDLE.
- `mul_done` asserted while in LO is a protocol violation. It is ignored: no new capture starts, and the current beat is still treated as lo.

FIFO behaviour:
- Push is accepted when count < DEPTH, or when a pop happens in the same cycle (full with out_ready=1).
- Otherwise the product is dropped, overflow ← 1, and FIFO contents and count are unchanged.
- Pop occurs when out_valid && out_ready. out_ready while empty has no effect.
- Simultaneous push and pop: count is unchanged, the head advances, and the new entry goes to the tail.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is the separate occupancy.
- out_product is the head entry combinationally (FWFT). It is a don't-care while out_valid=0, but the bench checks it only when valid.
- overflow: clr_ovf=1 clears it. If clr_ovf and a drop occur in the same cycle, the drop wins and overflow stays 1.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, hi_reg=0, pointers=0, count=0, out_valid=0, full=0, overflow=0. Storage contents need no reset. out_product is unspecified while out_valid=0.
- Reset release is synchronous to clk. The first capture can occur on the first edge after rst=1.
- Reset during LO discards the partial product. No push occurs.
- Latency: `mul_done` at edge T and lo at T+1; the push is registered at T+1. out_valid=1 in the cycle after edge T+1 if the FIFO was empty. Products are 2 cycles apart at the maximum rate.
- count, full and out_valid update on the same edge as a push or pop.
- One push per two cycles at most. One pop per cycle at most.

## Structure
- Shared package `mult_pkg` holds:
  - the capture state enum (IDLE, LO)
  - default W=5 and DEPTH=4
  - the product width constant PW = 2*W
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) holds pointers, count, storage, FWFT read, and full/empty.
- `product_collector` holds only the capture FSM, hi_reg, and overflow logic.

## Test plan
- Single product: reset, then mul_done with data 5'b11111, then 5'b01010; out_ready=0 → out_valid rises 2 cycles after mul_done, out_product=10'h3EA (−22), count=1.
- Fill and drop: four products 10'h001..10'h004 with out_ready=0, then a fifth (10'h005) → full=1, overflow=1, count stays 4. Draining yields 001,002,003,004 in order.
- Push and pop while full: FIFO full, out_ready=1 held across the lo beat of 10'h155 → overflow stays 0, count stays 4, 10'h155 appears as the fourth entry after the pops.
- Protocol violation: mul_done asserted on both the hi and lo beats with data 5'h03, 5'h07 → exactly one product 10'h067 is pushed, and the FSM is IDLE next cycle.
- Reset mid-capture: rst=0 in the cycle after mul_done → after release count=0, out_valid=0, and the next clean product is captured correctly.
- Overflow clear race: clr_ovf=1 in the same cycle as a drop → overflow=1. clr_ovf one cycle later → overflow=0.
